// File: rtl/pipeline_rf_wr_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package pipeline_rf_wr_arbiter_pkg;

    localparam int unsigned XLEN   = 64;
    localparam logic [4:0]  REG_X0 = 5'd0;

    typedef struct packed {
        logic            we;
        logic [4:0]      rd;
        logic [XLEN-1:0] wdata;
    } rf_wr_t;

    // Which source owns the write port in a given cycle.
    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PIPE,
        GNT_FIFO,
        GNT_STALL
    } grant_e;

endpackage

// File: rtl/pipeline_rf_wr_arbiter_fifo.sv
// Synchronous FIFO buffering MDU results until the write port is free.
module rf_wr_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 69
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic             almost_empty,
    output logic [WIDTH-1:0] rdata
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      used;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Extra pointer bit separates the wrapped (full) case from empty.
    assign used         = wr_ptr - rd_ptr;
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign almost_empty = (used == (AW+1)'(1));
    assign rdata        = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pipeline_rf_wr_arbiter.sv
// Register-file write-port arbiter: WB stage has priority, buffered MDU
// results drain in order, with a starvation stall to force progress.
module pipeline_rf_wr_arbiter #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned XLEN     = pipeline_rf_wr_arbiter_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pipe_we,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_wdata,
    input  logic            mdu_valid,
    input  logic [4:0]      mdu_rd,
    input  logic [XLEN-1:0] mdu_wdata,
    output logic            mdu_ready,
    output logic            stall_req,
    output logic            mdu_pending,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);

    import pipeline_rf_wr_arbiter_pkg::*;

    localparam int unsigned ENTRY_W = 5 + XLEN;
    localparam int unsigned WW      = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT);

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_one;
    logic [ENTRY_W-1:0] fifo_head;
    logic [4:0]         head_rd;
    logic [XLEN-1:0]    head_wdata;

    logic               pipe_req;
    logic               nonempty_next;
    logic [WW-1:0]      wait_cnt;
    logic [WW-1:0]      wait_next;
    logic               stall_next;
    grant_e             grant;

    assign mdu_ready   = !fifo_full;
    assign mdu_pending = !fifo_empty;

    // Results for x0 are acknowledged but never stored.
    assign fifo_push = mdu_valid && !fifo_full && (mdu_rd != REG_X0);
    assign pipe_req  = pipe_we && (pipe_rd != REG_X0);

    assign head_rd    = fifo_head[ENTRY_W-1 -: 5];
    assign head_wdata = fifo_head[XLEN-1:0];

    rf_wr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (fifo_push),
        .pop          (fifo_pop),
        .wdata        ({mdu_rd, mdu_wdata}),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .almost_empty (fifo_one),
        .rdata        (fifo_head)
    );

    always_comb begin
        grant     = GNT_NONE;
        fifo_pop  = 1'b0;
        wait_next = wait_cnt;

        if (stall_req) begin
            // Pipe bundle is frozen upstream this cycle, so it is never granted here.
            if (!fifo_empty) begin
                grant    = GNT_STALL;
                fifo_pop = 1'b1;
            end
            wait_next = '0;
        end else if (pipe_req) begin
            grant = GNT_PIPE;
            if (!fifo_empty && (wait_cnt != WAIT_SAT)) wait_next = wait_cnt + 1'b1;
        end else if (!fifo_empty) begin
            grant     = GNT_FIFO;
            fifo_pop  = 1'b1;
            wait_next = '0;
        end

        nonempty_next = fifo_push || !(fifo_empty || (fifo_pop && fifo_one));
        if (!nonempty_next) wait_next = '0;

        stall_next = nonempty_next && (wait_next == WAIT_SAT) && !stall_req;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= '0;
            stall_req <= 1'b0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
        end else begin
            wait_cnt  <= wait_next;
            stall_req <= stall_next;
            rf_we     <= (grant != GNT_NONE);
            case (grant)
                GNT_PIPE: begin
                    rf_waddr <= pipe_rd;
                    rf_wdata <= pipe_wdata;
                end
                GNT_FIFO, GNT_STALL: begin
                    rf_waddr <= head_rd;
                    rf_wdata <= head_wdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_rf_wr_arbiter.sv
// Scoreboard bench for pipeline_rf_wr_arbiter (DEPTH=2, MAX_WAIT=4).
module tb_pipeline_rf_wr_arbiter;

    localparam int unsigned XLEN = 64;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wr_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            pipe_we;
    logic [4:0]      pipe_rd;
    logic [XLEN-1:0] pipe_wdata;
    logic            mdu_valid;
    logic [4:0]      mdu_rd;
    logic [XLEN-1:0] mdu_wdata;
    logic            mdu_ready;
    logic            stall_req;
    logic            mdu_pending;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    always #5 clk = ~clk;

    pipeline_rf_wr_arbiter #(
        .DEPTH    (2),
        .MAX_WAIT (4),
        .XLEN     (XLEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pipe_we     (pipe_we),
        .pipe_rd     (pipe_rd),
        .pipe_wdata  (pipe_wdata),
        .mdu_valid   (mdu_valid),
        .mdu_rd      (mdu_rd),
        .mdu_wdata   (mdu_wdata),
        .mdu_ready   (mdu_ready),
        .stall_req   (stall_req),
        .mdu_pending (mdu_pending),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    // Monitor: every register-file write must match the next expected write.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            wr_t e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got x%0d=%0h, required no write", rf_waddr, rf_wdata);
            end else begin
                e = exp_q.pop_front();
                if (rf_waddr !== e.rd || rf_wdata !== e.data) begin
                    n_bad++;
                    $display("FAIL rf_write: got x%0d=%0h, required x%0d=%0h",
                             rf_waddr, rf_wdata, e.rd, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [XLEN-1:0] d);
        exp_q.push_back({rd, d});
    endtask

    task automatic cyc(input logic pw, input logic [4:0] prd, input logic [XLEN-1:0] pd,
                       input logic mv, input logic [4:0] mrd, input logic [XLEN-1:0] md);
        pipe_we    = pw;
        pipe_rd    = prd;
        pipe_wdata = pd;
        mdu_valid  = mv;
        mdu_rd     = mrd;
        mdu_wdata  = md;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    endtask

    initial begin
        reset = 1'b1;
        pipe_we = 1'b0; pipe_rd = '0; pipe_wdata = '0;
        mdu_valid = 1'b0; mdu_rd = '0; mdu_wdata = '0;
        #1 reset = 1'b0;
        #2;
        chk("reset_rf_we", XLEN'(rf_we), 0);
        chk("reset_rf_waddr", XLEN'(rf_waddr), 0);
        chk("reset_rf_wdata", rf_wdata, 0);
        chk("reset_stall", XLEN'(stall_req), 0);
        chk("reset_pending", XLEN'(mdu_pending), 0);
        @(negedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("reset_ready", XLEN'(mdu_ready), 1);

        // Idle pipe: MDU result goes through the FIFO and drains on its own.
        cyc(1'b0, 5'd0, '0, 1'b1, 5'd5, 64'h1234);
        chk("idle_pending_set", XLEN'(mdu_pending), 1);
        expect_wr(5'd5, 64'h1234);
        cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        chk("idle_pending_clr", XLEN'(mdu_pending), 0);
        idle(1);

        // Conflict: pipe writes x3 every cycle, one MDU result for x7 starves.
        cyc(1'b0, 5'd0, '0, 1'b1, 5'd7, 64'hBB);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("conf_stall_c%0d", i), XLEN'(stall_req), 0);
            expect_wr(5'd3, 64'hAA);
            cyc(1'b1, 5'd3, 64'hAA, 1'b0, 5'd0, '0);
        end
        chk("conf_stall_on", XLEN'(stall_req), 1);
        chk("conf_pending_on", XLEN'(mdu_pending), 1);
        expect_wr(5'd7, 64'hBB);
        cyc(1'b1, 5'd3, 64'hAA, 1'b0, 5'd0, '0);
        chk("conf_stall_off", XLEN'(stall_req), 0);
        chk("conf_pending_off", XLEN'(mdu_pending), 0);
        expect_wr(5'd3, 64'hAA);
        cyc(1'b1, 5'd3, 64'hAA, 1'b0, 5'd0, '0);
        idle(1);

        // Full FIFO: third result waits for a pop; drain order preserved.
        expect_wr(5'd2, 64'h22);
        cyc(1'b1, 5'd2, 64'h22, 1'b1, 5'd11, 64'h11);
        chk("full_ready_c1", XLEN'(mdu_ready), 1);
        expect_wr(5'd2, 64'h22);
        cyc(1'b1, 5'd2, 64'h22, 1'b1, 5'd12, 64'h12);
        for (int i = 2; i <= 4; i++) begin
            chk($sformatf("full_ready_c%0d", i), XLEN'(mdu_ready), 0);
            chk($sformatf("full_stall_c%0d", i), XLEN'(stall_req), 0);
            expect_wr(5'd2, 64'h22);
            cyc(1'b1, 5'd2, 64'h22, 1'b1, 5'd13, 64'h13);
        end
        chk("full_stall_c5", XLEN'(stall_req), 1);
        chk("full_ready_c5", XLEN'(mdu_ready), 0);
        expect_wr(5'd11, 64'h11);
        cyc(1'b1, 5'd2, 64'h22, 1'b1, 5'd13, 64'h13);
        chk("full_ready_c6", XLEN'(mdu_ready), 1);
        chk("full_stall_c6", XLEN'(stall_req), 0);
        expect_wr(5'd2, 64'h22);
        cyc(1'b1, 5'd2, 64'h22, 1'b1, 5'd13, 64'h13);
        for (int i = 7; i <= 9; i++) begin
            chk($sformatf("full_ready_c%0d", i), XLEN'(mdu_ready), 0);
            expect_wr(5'd2, 64'h22);
            cyc(1'b1, 5'd2, 64'h22, 1'b0, 5'd0, '0);
        end
        chk("full_stall_c10", XLEN'(stall_req), 1);
        expect_wr(5'd12, 64'h12);
        cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        chk("full_stall_c11", XLEN'(stall_req), 0);
        expect_wr(5'd13, 64'h13);
        cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        chk("full_pending_end", XLEN'(mdu_pending), 0);
        chk("full_ready_end", XLEN'(mdu_ready), 1);
        idle(1);

        // x0 filtering on both sources.
        chk("x0_ready", XLEN'(mdu_ready), 1);
        cyc(1'b1, 5'd0, 64'h55, 1'b1, 5'd0, 64'hFF);
        chk("x0_pending_a", XLEN'(mdu_pending), 0);
        cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        chk("x0_pending_b", XLEN'(mdu_pending), 0);
        idle(1);

        // Push and pop together at count 1.
        cyc(1'b0, 5'd0, '0, 1'b1, 5'd20, 64'hA0);
        chk("pp_pending_a", XLEN'(mdu_pending), 1);
        expect_wr(5'd20, 64'hA0);
        cyc(1'b0, 5'd0, '0, 1'b1, 5'd21, 64'hA1);
        chk("pp_pending_b", XLEN'(mdu_pending), 1);
        chk("pp_ready_b", XLEN'(mdu_ready), 1);
        expect_wr(5'd21, 64'hA1);
        cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        chk("pp_pending_c", XLEN'(mdu_pending), 0);
        idle(1);

        // Reset mid-operation discards buffered results.
        expect_wr(5'd1, 64'h1);
        cyc(1'b1, 5'd1, 64'h1, 1'b1, 5'd9, 64'h99);
        expect_wr(5'd1, 64'h1);
        cyc(1'b1, 5'd1, 64'h1, 1'b1, 5'd10, 64'h9A);
        chk("mid_pending", XLEN'(mdu_pending), 1);
        chk("mid_ready", XLEN'(mdu_ready), 0);
        @(negedge clk);
        #1;
        pipe_we = 1'b0; mdu_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_rf_we", XLEN'(rf_we), 0);
        chk("mid_rst_pending", XLEN'(mdu_pending), 0);
        chk("mid_rst_stall", XLEN'(stall_req), 0);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid_rel_ready", XLEN'(mdu_ready), 1);
        chk("mid_rel_pending", XLEN'(mdu_pending), 0);
        @(posedge clk);
        #1;
        idle(4);

        chk("drain_expected_empty", XLEN'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
